// File: rtl/ex_pkg.sv
// Shared types and constants for the EX-stage multiply/divide unit.
package ex_pkg;

    localparam int unsigned MD_ITER = 32;

    typedef enum logic [1:0] {
        MD_MUL   = 2'b00,
        MD_MULHU = 2'b01,
        MD_DIVU  = 2'b10,
        MD_REMU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } md_state_e;

endpackage

// File: rtl/md_step_dp.sv
// Iterative datapath: one shift-add multiply or restoring-divide step per cycle.
// acc holds {product_hi, product_lo} for multiply and {remainder, quotient} for divide.
module md_step_dp #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            step,
    input  logic            is_div,
    input  logic            div0,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] acc_hi,
    output logic [XLEN-1:0] acc_lo
);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   m_q, m_d;
    logic [XLEN:0]     sum, rem_sh, diff;

    always_comb begin
        acc_d  = acc_q;
        m_d    = m_q;
        sum    = '0;
        rem_sh = '0;
        diff   = '0;
        if (load) begin
            m_d = op_b;
            // Divide by zero preloads the architectural answer: quotient all-ones, remainder = dividend.
            acc_d = div0 ? {op_a, {XLEN{1'b1}}} : {{XLEN{1'b0}}, op_a};
        end else if (step) begin
            if (is_div) begin
                rem_sh = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
                diff   = rem_sh - (XLEN+1)'(m_q);
                if (rem_sh >= (XLEN+1)'(m_q)) begin
                    acc_d = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                end
            end else begin
                sum   = (XLEN+1)'(acc_q[2*XLEN-1:XLEN]) + (acc_q[0] ? (XLEN+1)'(m_q) : (XLEN+1)'(0));
                acc_d = {sum, acc_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            m_q   <= '0;
        end else begin
            acc_q <= acc_d;
            m_q   <= m_d;
        end
    end

    assign acc_hi = acc_q[2*XLEN-1:XLEN];
    assign acc_lo = acc_q[XLEN-1:0];

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// Multi-cycle MUL/MULHU/DIVU/REMU controller: FSM, iteration counter and pipeline handshake.
module ex_muldiv_ctrl
    import ex_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned MD_ITER = ex_pkg::MD_ITER
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      md_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CNT_W = $clog2(MD_ITER) + 1;

    md_state_e         state_q, state_d;
    md_op_e            op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              load, step, div0;
    logic [XLEN-1:0]   acc_hi, acc_lo, dp_res;

    assign dp_res = (op_q inside {MD_MULHU, MD_REMU}) ? acc_hi : acc_lo;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        load     = 1'b0;
        step     = 1'b0;
        div0     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    op_d    = md_op_e'(md_op);
                    cnt_d   = '0;
                    load    = 1'b1;
                    div0    = md_op[1] && (op_b == '0);
                    state_d = div0 ? DONE : RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(MD_ITER - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!flush) begin
                    result_d = dp_res;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            op_q     <= MD_MUL;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    md_step_dp #(.XLEN(XLEN)) u_dp (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .is_div (op_q inside {MD_DIVU, MD_REMU}),
        .div0   (div0),
        .op_a   (op_a),
        .op_b   (op_b),
        .acc_hi (acc_hi),
        .acc_lo (acc_lo)
    );

    // A flush during DONE suppresses the pulse, so the new result is only exposed with done.
    assign busy   = (state_q != IDLE);
    assign stall  = reset && (((state_q == IDLE) && start && !flush) || (state_q == RUN));
    assign done   = (state_q == DONE) && !flush;
    assign result = done ? dp_res : result_q;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed plus random checks of ex_muldiv_ctrl against a plain-arithmetic reference model.
module tb_ex_muldiv_ctrl;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned MD_ITER = 32;

    logic            clk;
    logic            reset;
    logic            start;
    logic [1:0]      md_op;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] last_res = '0;

    ex_muldiv_ctrl #(.XLEN(XLEN), .MD_ITER(MD_ITER)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        int lat;
        int stalls;
        int exp_lat;
        bit seen;
        exp     = model(op, a, b);
        exp_lat = (op[1] && b == 0) ? 1 : MD_ITER + 1;
        @(negedge clk);
        start = 1'b1; md_op = op; op_a = a; op_b = b; flush = 1'b0;
        #1;
        check("accept_stall", 32'(stall), 32'd1);
        check("accept_busy", 32'(busy), 32'd0);
        stalls = 1;
        lat    = 0;
        seen   = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            // Operands and start wiggle while busy; the unit must ignore them.
            start = 1'($urandom_range(0, 1));
            op_a  = $urandom;
            op_b  = $urandom;
            md_op = 2'($urandom_range(0, 3));
            #1;
            if (stall) stalls++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check("done_seen", 32'(seen), 32'd1);
        check("latency", 32'(lat), 32'(exp_lat));
        check("stall_cycles", 32'(stalls), 32'(exp_lat));
        check("result", result, exp);
        check("done_busy", 32'(busy), 32'd1);
        @(negedge clk);
        #1;
        check("post_done", 32'(done), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
        check("result_hold", result, exp);
        last_res = exp;
    endtask

    initial begin
        int nodone;
        reset = 1'b0; start = 1'b1; md_op = '0; op_a = '0; op_b = '0; flush = 1'b0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        start = 1'b0;
        @(posedge clk); #2 reset = 1'b1;

        do_op(2'd0, 32'd10, 32'd5);
        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(2'd2, 32'd100, 32'd7);
        do_op(2'd3, 32'd100, 32'd7);
        do_op(2'd2, 32'd42, 32'd0);
        do_op(2'd3, 32'd42, 32'd0);

        // Flush in RUN cycle 10.
        @(negedge clk);
        start = 1'b1; md_op = 2'd0; op_a = 32'd3; op_b = 32'd9;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        flush = 1'b1;
        #1;
        check("flush_run_busy", 32'(busy), 32'd1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_done", 32'(done), 32'd0);
        check("flush_result", result, last_res);
        nodone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (done) nodone++;
        end
        check("flush_no_done", 32'(nodone), 32'd0);
        do_op(2'd2, 32'd1000, 32'd33);

        // Start with flush in IDLE is ignored.
        @(negedge clk);
        start = 1'b1; flush = 1'b1;
        #1;
        check("idle_flush_stall", 32'(stall), 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        check("idle_flush_busy", 32'(busy), 32'd0);

        // Reset mid-RUN.
        @(negedge clk);
        start = 1'b1; md_op = 2'd1; op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF0;
        for (int i = 0; i < 15; i++) @(negedge clk);
        start = 1'b1;
        reset = 1'b0;
        #1;
        check("midrun_rst_busy", 32'(busy), 32'd0);
        check("midrun_rst_stall", 32'(stall), 32'd0);
        check("midrun_rst_done", 32'(done), 32'd0);
        check("midrun_rst_result", result, 32'd0);
        start = 1'b0;
        last_res = '0;
        @(posedge clk); #2 reset = 1'b1;
        do_op(2'd3, 32'hDEAD_BEEF, 32'd1234);

        // Random mix, back to back.
        for (int i = 0; i < 20; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = ($urandom_range(0, 4) == 0) ? 32'd0 :
                 ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            do_op(2'($urandom_range(0, 3)), ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_ctrl.md
EX_MULDIV_CTRL -- requirements
Module: ex_muldiv_ctrl

Interface
REQ-001 SHALL use parameter XLEN, default 32, for the operand and result width.
REQ-002 SHALL use parameter MD_ITER, default 32, for the iteration count of a multiply or divide.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-low; reset=0 forces the reset state immediately.
REQ-005 SHALL have port start, input, 1, request a multiply or divide operation from the EX stage.
REQ-006 SHALL have port md_op, input, 2, operation: 00 MUL, 01 MULHU, 10 DIVU, 11 REMU.
REQ-007 SHALL have port op_a, input, XLEN, multiplicand or dividend.
REQ-008 SHALL have port op_b, input, XLEN, multiplier or divisor.
REQ-009 SHALL have port flush, input, 1, abort the current operation because of a pipeline flush.
REQ-010 SHALL have port busy, output, 1, operation in progress.
REQ-011 SHALL have port stall, output, 1, hold the IF, ID and EX stages.
REQ-012 SHALL have port done, output, 1, one-cycle pulse; result is valid.
REQ-013 SHALL have port result, output, XLEN, completed result.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 SHALL sample start only in IDLE; start in RUN or DONE is ignored.
REQ-016 SHALL, in IDLE with start=1 and flush=0, latch op_a, op_b and md_op, clear the iteration counter, and go to RUN.
REQ-017 SHALL perform one shift-add (MUL/MULHU) or restoring-subtract (DIVU/REMU) step per RUN cycle.
REQ-018 SHALL go from RUN to DONE on the edge that completes iteration MD_ITER, so done is high in the cycle after edge N+32, where edge N is the accept edge.
REQ-019 SHALL, in DONE, assert done=1 for exactly one cycle and drive result, then return to IDLE.
REQ-020 SHALL, for MUL, return product[31:0]; for MULHU, return unsigned product[63:32] of a 64-bit product.
REQ-021 SHALL, for DIVU, return the unsigned quotient; for REMU, return the unsigned remainder.
REQ-022 SHALL treat divide by zero (DIVU/REMU, op_b=0) as a special case: IDLE goes straight to DONE on the accept edge; DIVU returns 0xFFFFFFFF and REMU returns op_a.
REQ-023 SHALL drive busy=1 in RUN and DONE, and busy=0 in IDLE.
REQ-024 SHALL drive stall = (IDLE and start and not flush) or RUN; stall=0 in DONE so the pipeline advances in the same cycle as done.
REQ-025 SHALL, on flush=1 in RUN or DONE, go to IDLE on the next edge with no done pulse and result unchanged.
REQ-026 SHALL ignore start when flush=1 in IDLE.
REQ-027 SHALL hold result at its last completed value until the next DONE.
REQ-028 SHALL use a counter of clog2(MD_ITER)+1 bits that never wraps; it is cleared on accept.

Reset
REQ-029 SHALL, on reset=0, set state=IDLE, the counter to 0, busy=0, stall=0, done=0, result=0, and clear all internal operand registers.
REQ-030 SHALL, on reset asserted mid-RUN, abandon the operation and produce no done after release.
REQ-031 SHALL, on the first edge after reset release with start=1, accept the operation normally.

Structure
REQ-032 SHALL define in shared package ex_pkg: md_op_e (MD_MUL, MD_MULHU, MD_DIVU, MD_REMU), md_state_e (IDLE, RUN, DONE) and MD_ITER.
REQ-033 SHALL place the per-iteration arithmetic step (64-bit accumulator or remainder/quotient register shift) in one sub-module, md_step_dp; the FSM, counter and handshake stay in ex_muldiv_ctrl.

Verification
REQ-034 SHALL cover MUL: op_a=10, op_b=5 -> stall high for 33 cycles, done pulse at cycle 33, result=50.
REQ-035 SHALL cover MULHU: op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> result=0xFFFFFFFE; MUL with the same operands -> result=0x00000001.
REQ-036 SHALL cover DIVU and REMU: op_a=100, op_b=7 -> DIVU result=14, REMU result=2, each after 33 cycles.
REQ-037 SHALL cover divide by zero: DIVU op_a=42, op_b=0 -> done one cycle after accept, result=0xFFFFFFFF; REMU -> result=42.
REQ-038 SHALL cover flush: flush at RUN cycle 10 -> IDLE next edge, no done, busy=0, result still holds the prior value; a new start is then accepted.
REQ-039 SHALL cover reset: reset=0 asserted mid-RUN -> all outputs 0 immediately; back-to-back start in IDLE after DONE accepted with correct results.
